lcd_timing_ctrl: RTL

Generates parallel-RGB LCD raster timing (DEN, HSYNC, VSYNC, X, Y) that sequences the pixel pattern generators downstream. Also produces a once-per-N-frames animation tick, which replaces ad-hoc free-running cycle counters in pattern blocks. An ENABLE start/stop control starts on a frame boundary and always finishes the current frame before going idle. Sits between the clock/PLL block and the pixel data_out stage.

---
 rtl/lcd_timing_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/lcd_timing_ctrl.sv
// Parallel-RGB LCD raster timing generator: DEN/HSYNC/VSYNC/X/Y plus frame-start
// and divided animation tick, with an ENABLE control that only stops on frame boundaries.
module lcd_timing_ctrl #(
    parameter int LCD_WIDTH  = 480,
    parameter int H_FP       = 8,
    parameter int H_SYNC     = 4,
    parameter int H_BP       = 43,
    parameter int LCD_HEIGHT = 272,
    parameter int V_FP       = 8,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 12,
    parameter int ANIM_DIV   = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ENABLE,
    output logic        DEN,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [10:0] X,
    output logic [10:0] Y,
    output logic        FRAME_START,
    output logic        FRAME_TICK,
    output logic        BUSY
);
    localparam int H_TOTAL = LCD_WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = LCD_HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int DW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [10:0] H_ACT  = 11'(LCD_WIDTH);
    localparam logic [10:0] HS_BEG = 11'(LCD_WIDTH + H_FP);
    localparam logic [10:0] HS_END = 11'(LCD_WIDTH + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(LCD_HEIGHT);
    localparam logic [10:0] VS_BEG = 11'(LCD_HEIGHT + V_FP);
    localparam logic [10:0] VS_END = 11'(LCD_HEIGHT + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [10:0]   hcnt, vcnt;
    logic [DW-1:0] div;

    logic h_act, v_act, h_sync, v_sync, line_end, frame_end, vs_fall;

    assign h_act     = hcnt < H_ACT;
    assign v_act     = vcnt < V_ACT;
    assign h_sync    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign v_sync    = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign line_end  = hcnt == H_LAST;
    assign frame_end = line_end && (vcnt == V_LAST);
    // First counter position of the V sync region; its registered decode is the VSYNC fall
    assign vs_fall   = (hcnt == '0) && (vcnt == VS_BEG);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            div         <= '0;
            DEN         <= 1'b0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            X           <= '0;
            Y           <= '0;
            FRAME_START <= 1'b0;
            FRAME_TICK  <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            BUSY <= (state != IDLE);
            case (state)
                IDLE: begin
                    hcnt        <= '0;
                    vcnt        <= '0;
                    div         <= '0;
                    DEN         <= 1'b0;
                    HSYNC       <= 1'b1;
                    VSYNC       <= 1'b1;
                    X           <= '0;
                    Y           <= '0;
                    FRAME_START <= 1'b0;
                    FRAME_TICK  <= 1'b0;
                    if (ENABLE) state <= RUN;
                end
                default: begin
                    DEN         <= h_act && v_act;
                    X           <= (h_act && v_act) ? hcnt : '0;
                    Y           <= (h_act && v_act) ? vcnt : '0;
                    HSYNC       <= !h_sync;
                    VSYNC       <= !v_sync;
                    FRAME_START <= (hcnt == '0) && (vcnt == '0);
                    FRAME_TICK  <= vs_fall && (div == DIV_LAST);
                    if (vs_fall) div <= (div == DIV_LAST) ? '0 : div + 1'b1;

                    hcnt <= line_end ? '0 : hcnt + 11'd1;
                    if (line_end) vcnt <= frame_end ? '0 : vcnt + 11'd1;

                    // DRAIN keeps counting so a stop request never truncates a frame
                    if (state == RUN) begin
                        if (!ENABLE) state <= DRAIN;
                    end else if (ENABLE) begin
                        state <= RUN;
                    end else if (frame_end) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
